// File: rtl/serial_parallel_onehot_signed_16_outputs.sv
// rtl/serial_parallel_onehot_signed_16_outputs.sv - expands one (index, value) pair into NUM_CHUNKS serial 16-lane one-hot chunks
module serial_parallel_onehot_signed_16_outputs #(
  parameter int WIDTH        = 8,
  parameter int ARGMAX_WIDTH = 8,
  parameter int NUM_CHUNKS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic        [ARGMAX_WIDTH-1:0] in_argmax,
  input  logic signed [WIDTH-1:0]        in_value,
  output logic                           busy,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic signed [WIDTH-1:0]        out [15:0],
  output logic        [ARGMAX_WIDTH-5:0] out_chunk,
  output logic                           out_last,
  output logic                           out_of_range
);

  localparam int CW = ARGMAX_WIDTH - 4;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);
  // One extra bit so 16*NUM_CHUNKS == 2^ARGMAX_WIDTH does not wrap to zero.
  localparam logic [ARGMAX_WIDTH:0] LANE_COUNT = (ARGMAX_WIDTH + 1)'(16 * NUM_CHUNKS);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ARGMAX_WIDTH-1:0]  idx_q;
  logic signed [WIDTH-1:0]  val_q;
  logic                     accept;
  logic                     advance;
  logic                     finish;
  logic [CW-1:0]            chunk_next;
  logic [ARGMAX_WIDTH-1:0]  sel_idx;
  logic signed [WIDTH-1:0]  sel_val;
  logic signed [WIDTH-1:0]  lanes_next [15:0];

  // State register; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: accept start only in IDLE, step the chunk on each transfer,
  // and return to IDLE on the transfer of the final chunk.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    chunk_next = out_chunk;
    sel_idx    = idx_q;
    sel_val    = val_q;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = STREAM;
          chunk_next = '0;
          sel_idx    = in_argmax;
          sel_val    = in_value;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (out_chunk == LAST_CHUNK) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            chunk_next = out_chunk + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane contents of the chunk about to be presented: only the lane whose global
  // index matches carries the value. Out-of-range indices never match.
  always_comb begin
    for (int j = 0; j < 16; j++) begin
      lanes_next[j] = ({chunk_next, 4'(j)} == sel_idx) ? sel_val : '0;
    end
  end

  // Registered outputs and frame context; outputs only change on accept or transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q        <= '0;
      val_q        <= '0;
      out_of_range <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      out_last     <= 1'b0;
      out_chunk    <= '0;
      for (int j = 0; j < 16; j++) out[j] <= '0;
    end else begin
      if (accept) begin
        idx_q        <= in_argmax;
        val_q        <= in_value;
        out_of_range <= ({1'b0, in_argmax} >= LANE_COUNT);
      end
      if (accept || advance) begin
        out_valid <= 1'b1;
        busy      <= 1'b1;
        out_chunk <= chunk_next;
        out_last  <= (chunk_next == LAST_CHUNK);
        for (int j = 0; j < 16; j++) out[j] <= lanes_next[j];
      end else if (finish) begin
        out_valid <= 1'b0;
        busy      <= 1'b0;
        out_last  <= 1'b0;
        out_chunk <= '0;
        for (int j = 0; j < 16; j++) out[j] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_parallel_onehot_signed_16_outputs.sv
// tb/tb_serial_parallel_onehot_signed_16_outputs.sv - randomized self-checking bench for the one-hot chunk expander
module tb_serial_parallel_onehot_signed_16_outputs;

  logic              clk;
  logic              rst;
  logic              start;
  logic              start4;
  logic [7:0]        in_argmax;
  logic signed [7:0] in_value;
  logic              out_ready;

  logic              busy_a, valid_a, last_a, oor_a;
  logic signed [7:0] out_a [15:0];
  logic [3:0]        chunk_a;
  logic              busy_b, valid_b, last_b, oor_b;
  logic signed [7:0] out_b [15:0];
  logic [3:0]        chunk_b;

  int n_checks;
  int n_fail;

  logic         sel4;
  logic         obs_busy, obs_valid, obs_last, obs_oor;
  logic [3:0]   obs_chunk;
  logic [127:0] obs_lanes;

  serial_parallel_onehot_signed_16_outputs dut (
    .clk(clk), .rst(rst), .start(start), .in_argmax(in_argmax), .in_value(in_value),
    .busy(busy_a), .out_ready(out_ready), .out_valid(valid_a), .out(out_a),
    .out_chunk(chunk_a), .out_last(last_a), .out_of_range(oor_a)
  );

  serial_parallel_onehot_signed_16_outputs #(.NUM_CHUNKS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_argmax(in_argmax), .in_value(in_value),
    .busy(busy_b), .out_ready(out_ready), .out_valid(valid_b), .out(out_b),
    .out_chunk(chunk_b), .out_last(last_b), .out_of_range(oor_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_busy  = sel4 ? busy_b  : busy_a;
    obs_valid = sel4 ? valid_b : valid_a;
    obs_last  = sel4 ? last_b  : last_a;
    obs_oor   = sel4 ? oor_b   : oor_a;
    obs_chunk = sel4 ? chunk_b : chunk_a;
    obs_lanes = '0;
    for (int j = 0; j < 16; j++) obs_lanes[j*8 +: 8] = sel4 ? out_b[j] : out_a[j];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: global lane index of (chunk c, lane j) is 16*c+j.
  function automatic logic [127:0] model_lanes(input int idx, input int val, input int c);
    logic [127:0] v;
    logic [31:0]  vb;
    v  = '0;
    vb = val;
    for (int j = 0; j < 16; j++)
      if (idx == 16 * c + j) v[j*8 +: 8] = vb[7:0];
    return v;
  endfunction

  // mode 0: ready always high, 1: toggle 1,0,1,0..., 2: random ready.
  task automatic run_frame(input int idx, input int val, input int nch, input int mode, input bit poke);
    int c;
    int cyc;
    bit rdy;
    sel4      = (nch == 4);
    in_argmax = 8'(idx);
    in_value  = 8'(val);
    if (sel4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
    check("out_of_range", obs_oor, (idx >= 16 * nch) ? 1 : 0);
    c   = 0;
    cyc = 0;
    while (c < nch && cyc < 200) begin
      check("valid", obs_valid, 1);
      check("busy", obs_busy, 1);
      check("chunk", obs_chunk, c);
      check("last", obs_last, (c == nch - 1) ? 1 : 0);
      check("lanes", obs_lanes, model_lanes(idx, val, c));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (poke && (c == 7 || c == nch - 1)) begin
        if (sel4) start4 = 1'b1; else start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      start4 = 1'b0;
      if (rdy) c++;
      cyc++;
    end
    check("transfers", c, nch);
    if (mode == 0) check("busy_cycles", cyc, nch);
    if (mode == 1) check("toggle_cycles", cyc, 2 * nch - 1);
    check("idle_valid", obs_valid, 0);
    check("idle_busy", obs_busy, 0);
    check("idle_last", obs_last, 0);
    check("oor_held", obs_oor, (idx >= 16 * nch) ? 1 : 0);
    if (poke) begin
      out_ready = 1'b1;
      repeat (3) begin
        @(posedge clk);
        @(negedge clk);
        check("no_second_frame", obs_valid, 0);
      end
    end
  endtask

  initial begin
    int idx;
    int val;
    n_checks  = 0;
    n_fail    = 0;
    sel4      = 1'b0;
    rst       = 1'b0;
    start     = 1'b0;
    start4    = 1'b0;
    in_argmax = '0;
    in_value  = '0;
    out_ready = 1'b1;

    #3;
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_last", last_a, 0);
    check("rst_oor", oor_a, 0);
    check("rst_chunk", chunk_a, 0);
    check("rst_lanes", obs_lanes, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Start issued on the first edge after reset release.
    run_frame(37, -5, 16, 0, 0);
    run_frame(0, 127, 16, 1, 0);
    run_frame(255, -128, 16, 0, 0);
    run_frame(100, 33, 4, 0, 0);
    run_frame(50, -7, 4, 2, 0);
    run_frame(90, 0, 16, 0, 0);
    run_frame(200, 77, 16, 0, 1);

    for (int k = 0; k < 5; k++) begin
      idx = int'($urandom_range(0, 255));
      val = int'($urandom_range(0, 255)) - 128;
      run_frame(idx, val, 16, 2, 0);
    end
    for (int k = 0; k < 4; k++) begin
      idx = int'($urandom_range(0, 127));
      val = int'($urandom_range(0, 255)) - 128;
      run_frame(idx, val, 4, 2, 0);
    end

    // Reset in the middle of chunk 5 clears outputs without a clock edge.
    sel4      = 1'b0;
    out_ready = 1'b1;
    in_argmax = 8'd37;
    in_value  = -8'sd5;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_chunk", chunk_a, 5);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", valid_a, 0);
    check("async_busy", busy_a, 0);
    check("async_chunk", chunk_a, 0);
    check("async_last", last_a, 0);
    check("async_lanes", obs_lanes, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_quiet", valid_a, 0);
    end
    run_frame(37, -5, 16, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
